// File: rtl/char_plane_pkg.sv
// Shared geometry, control codes and FSM encoding for the character plane.
package char_plane_pkg;

    localparam int ROW_NUMBER     = 15;
    localparam int COL_NUMBER     = 40;
    localparam int CHAR_ID_LENGTH = 8;
    localparam int ROW_BIT_LEN    = 4;
    localparam int COL_BIT_LEN    = 6;

    localparam int CELLS  = ROW_NUMBER * COL_NUMBER;
    localparam int ADDR_W = $clog2(CELLS);

    localparam logic [CHAR_ID_LENGTH-1:0] BLANK_ID  = CHAR_ID_LENGTH'(8'h20);
    localparam logic [CHAR_ID_LENGTH-1:0] PRINT_MIN = CHAR_ID_LENGTH'(8'h20);

    localparam logic [CHAR_ID_LENGTH-1:0] CC_NL = CHAR_ID_LENGTH'(8'h0A);
    localparam logic [CHAR_ID_LENGTH-1:0] CC_CR = CHAR_ID_LENGTH'(8'h0D);
    localparam logic [CHAR_ID_LENGTH-1:0] CC_BS = CHAR_ID_LENGTH'(8'h08);
    localparam logic [CHAR_ID_LENGTH-1:0] CC_FF = CHAR_ID_LENGTH'(8'h0C);

    localparam logic [ROW_BIT_LEN-1:0] LAST_ROW  = ROW_BIT_LEN'(ROW_NUMBER - 1);
    localparam logic [COL_BIT_LEN-1:0] LAST_COL  = COL_BIT_LEN'(COL_NUMBER - 1);
    localparam logic [ADDR_W-1:0]      LAST_CELL = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0]      LAST_RCOL = ADDR_W'(COL_NUMBER - 1);

    typedef enum logic [1:0] {
        ST_CLR_ALL = 2'd0,
        ST_IDLE    = 2'd1,
        ST_CLR_ROW = 2'd2
    } state_t;

endpackage

// File: rtl/char_plane_ram.sv
// Character storage: one write port, one registered read port (read-before-write).
module char_plane_ram
    import char_plane_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         waddr,
    input  logic [CHAR_ID_LENGTH-1:0] wdata,
    input  logic [ADDR_W-1:0]         raddr,
    input  logic                      rblank,
    output logic [CHAR_ID_LENGTH-1:0] rdata
);

    logic [CHAR_ID_LENGTH-1:0] mem [CELLS];

    // Cell write; storage itself is never reset, the clear sequence blanks it.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read; sees the pre-write contents on an address collision.
    always_ff @(posedge clk) begin
        if (!rst_n)      rdata <= '0;
        else if (rblank) rdata <= BLANK_ID;
        else             rdata <= mem[raddr];
    end

endmodule

// File: rtl/char_plane_ctrl.sv
// Text-mode character plane: cursor/write engine, circular scroll offset, read port.
module char_plane_ctrl
    import char_plane_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [CHAR_ID_LENGTH-1:0] in_char,
    output logic                      in_ready,
    input  logic [ROW_BIT_LEN-1:0]    rd_row,
    input  logic [COL_BIT_LEN-1:0]    rd_col,
    output logic [CHAR_ID_LENGTH-1:0] rd_char,
    output logic [ROW_BIT_LEN-1:0]    cursor_row,
    output logic [COL_BIT_LEN-1:0]    cursor_col,
    output logic                      busy
);

    state_t                   state;
    logic [ADDR_W-1:0]        cnt;
    logic [ROW_BIT_LEN-1:0]   top;
    logic [ROW_BIT_LEN-1:0]   clr_row;

    logic                     accept, is_print, do_nl, bs_ok;
    logic [ROW_BIT_LEN-1:0]   bs_row;
    logic [COL_BIT_LEN-1:0]   bs_col;
    logic                     we_c;
    logic [ADDR_W-1:0]        waddr_c;
    logic [CHAR_ID_LENGTH-1:0] wdata_c;
    logic                     rblank;
    logic [ADDR_W-1:0]        raddr;

    // Logical row to physical row: (row + offs) mod ROW_NUMBER without a divider.
    function automatic logic [ROW_BIT_LEN-1:0] to_phys(input logic [ROW_BIT_LEN-1:0] row,
                                                       input logic [ROW_BIT_LEN-1:0] offs);
        logic [ROW_BIT_LEN:0] s;
        s = {1'b0, row} + {1'b0, offs};
        if (s >= (ROW_BIT_LEN+1)'(ROW_NUMBER)) s = s - (ROW_BIT_LEN+1)'(ROW_NUMBER);
        return s[ROW_BIT_LEN-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_BIT_LEN-1:0] prow,
                                                    input logic [COL_BIT_LEN-1:0] col);
        return ADDR_W'(prow) * ADDR_W'(COL_NUMBER) + ADDR_W'(col);
    endfunction

    assign accept   = (state == ST_IDLE) && in_valid;
    assign is_print = (in_char >= PRINT_MIN);
    assign do_nl    = accept && ((is_print && cursor_col == LAST_COL) || in_char == CC_NL);
    assign bs_ok    = (cursor_row != '0) || (cursor_col != '0);
    assign bs_row   = (cursor_col != '0) ? cursor_row : cursor_row - ROW_BIT_LEN'(1);
    assign bs_col   = (cursor_col != '0) ? cursor_col - COL_BIT_LEN'(1) : LAST_COL;

    assign rblank = (rd_row >= ROW_BIT_LEN'(ROW_NUMBER)) || (rd_col >= COL_BIT_LEN'(COL_NUMBER));
    assign raddr  = cell_addr(to_phys(rd_row, top), rd_col);

    // Write-port source select: clear sequencers or the accepted character.
    always_comb begin
        we_c    = 1'b0;
        waddr_c = '0;
        wdata_c = BLANK_ID;
        case (state)
            ST_CLR_ALL: begin
                we_c    = 1'b1;
                waddr_c = cnt;
            end
            ST_CLR_ROW: begin
                we_c    = 1'b1;
                waddr_c = cell_addr(clr_row, COL_BIT_LEN'(cnt));
            end
            default: begin
                if (accept && is_print) begin
                    we_c    = 1'b1;
                    waddr_c = cell_addr(to_phys(cursor_row, top), cursor_col);
                    wdata_c = in_char;
                end else if (accept && in_char == CC_BS && bs_ok) begin
                    we_c    = 1'b1;
                    waddr_c = cell_addr(to_phys(bs_row, top), bs_col);
                end
            end
        endcase
    end

    char_plane_ram u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we_c && rst_n),
        .waddr  (waddr_c),
        .wdata  (wdata_c),
        .raddr  (raddr),
        .rblank (rblank),
        .rdata  (rd_char)
    );

    // Control FSM: clear sequencing, cursor movement and scroll offset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_CLR_ALL;
            cnt        <= '0;
            top        <= '0;
            clr_row    <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
        end else begin
            case (state)
                ST_CLR_ALL, ST_CLR_ROW: begin
                    if ((state == ST_CLR_ALL && cnt == LAST_CELL) ||
                        (state == ST_CLR_ROW && cnt == LAST_RCOL)) begin
                        state    <= ST_IDLE;
                        cnt      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (do_nl) begin
                        cursor_col <= '0;
                        if (cursor_row < LAST_ROW) begin
                            cursor_row <= cursor_row + ROW_BIT_LEN'(1);
                        end else begin
                            // Old top row becomes the new bottom row; blank it in place.
                            clr_row  <= top;
                            top      <= (top == LAST_ROW) ? '0 : top + ROW_BIT_LEN'(1);
                            state    <= ST_CLR_ROW;
                            cnt      <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end else if (accept) begin
                        if (is_print) begin
                            cursor_col <= cursor_col + COL_BIT_LEN'(1);
                        end else if (in_char == CC_CR) begin
                            cursor_col <= '0;
                        end else if (in_char == CC_BS) begin
                            if (bs_ok) begin
                                cursor_row <= bs_row;
                                cursor_col <= bs_col;
                            end
                        end else if (in_char == CC_FF) begin
                            cursor_row <= '0;
                            cursor_col <= '0;
                            top        <= '0;
                            state      <= ST_CLR_ALL;
                            cnt        <= '0;
                            in_ready   <= 1'b0;
                            busy       <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= ST_CLR_ALL;
                    cnt      <= '0;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_char_plane_ctrl.sv
// Directed bench for char_plane_ctrl with a read-data scoreboard.
module tb_char_plane_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_char;
    logic       in_ready;
    logic [3:0] rd_row;
    logic [5:0] rd_col;
    logic [7:0] rd_char;
    logic [3:0] cursor_row;
    logic [5:0] cursor_col;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int n;
    logic [7:0] exp_q [$];
    logic [7:0] exp_v;

    char_plane_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_char    (in_char),
        .in_ready   (in_ready),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_char    (rd_char),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Issue one read, remember its expected value, compare it one cycle later.
    task automatic rd_check(input string tag, input int r, input int c, input logic [7:0] e);
        rd_row = 4'(r);
        rd_col = 6'(c);
        exp_q.push_back(e);
        tick();
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL %s observed=empty-queue expected=entry", tag);
        end else begin
            exp_v = exp_q.pop_front();
            assert (rd_char === exp_v) else begin
                fails++;
                $error("FAIL %s r=%0d c=%0d observed=%0h expected=%0h", tag, r, c, rd_char, exp_v);
            end
        end
    endtask

    // Present one character and hold it until accepted (bounded).
    task automatic send(input logic [7:0] ch);
        int k;
        in_valid = 1'b1;
        in_char  = ch;
        k = 0;
        while (!in_ready && k < 2000) begin
            tick();
            k++;
        end
        if (k >= 2000) check("send_timeout", 1, 0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 5000) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_char  = 8'h00;
        rd_row   = '0;
        rd_col   = '0;
        repeat (3) tick();

        // Reset state
        check("rst_busy", busy, 1);
        check("rst_ready", in_ready, 0);
        check("rst_crow", cursor_row, 0);
        check("rst_ccol", cursor_col, 0);
        check("rst_rdchar", rd_char, 0);

        // Power-up clear takes one cycle per cell
        rst_n = 1'b1;
        wait_idle(n);
        check("clr_all_len", n, 600);
        check("idle_ready", in_ready, 1);
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 40; c++)
                rd_check("init_blank", r, c, 8'h20);
        rd_check("oob_row", 15, 0, 8'h20);

        // Single printable
        send(8'h41);
        check("a_crow", cursor_row, 0);
        check("a_ccol", cursor_col, 1);
        rd_check("a_cell", 0, 0, 8'h41);
        rd_check("a_next", 0, 1, 8'h20);

        // Ignored control code
        send(8'h01);
        check("ign_ccol", cursor_col, 1);
        check("ign_ready", in_ready, 1);

        // CR then a full row wraps onto row 1
        send(8'h0D);
        check("cr_ccol", cursor_col, 0);
        for (int i = 0; i < 40; i++) send(8'(8'h30 + i));
        check("row_crow", cursor_row, 1);
        check("row_ccol", cursor_col, 0);
        check("row_ready", in_ready, 1);
        rd_check("row_c0", 0, 0, 8'h30);
        rd_check("row_c20", 0, 20, 8'h44);
        rd_check("row_c39", 0, 39, 8'h57);
        rd_check("oob_col", 0, 40, 8'h20);

        // Backspace across a line boundary, then at the origin
        send(8'h08);
        check("bs_crow", cursor_row, 0);
        check("bs_ccol", cursor_col, 39);
        rd_check("bs_cell", 0, 39, 8'h20);
        send(8'h0D);
        send(8'h08);
        check("bs0_crow", cursor_row, 0);
        check("bs0_ccol", cursor_col, 0);
        rd_check("bs0_cell", 0, 0, 8'h30);

        // Walk down to the last row and scroll once
        for (int i = 0; i < 14; i++) send(8'h0A);
        check("nl_crow", cursor_row, 14);
        send(8'h42);
        send(8'h0A);
        check("scr_busy", busy, 1);
        check("scr_ready", in_ready, 0);
        wait_idle(n);
        check("clr_row_len", n, 40);
        check("scr_crow", cursor_row, 14);
        check("scr_ccol", cursor_col, 0);
        rd_check("scr_moved", 13, 0, 8'h42);
        for (int c = 0; c < 40; c++) rd_check("scr_blank", 14, c, 8'h20);
        rd_check("scr_top", 0, 0, 8'h20);

        // Reset in the middle of a row clear
        send(8'h0A);
        repeat (10) tick();
        check("mid_busy_pre", busy, 1);
        rst_n = 1'b0;
        tick();
        check("mid_busy", busy, 1);
        check("mid_ready", in_ready, 0);
        check("mid_crow", cursor_row, 0);
        check("mid_ccol", cursor_col, 0);
        check("mid_rdchar", rd_char, 0);
        rst_n = 1'b1;
        wait_idle(n);
        check("mid_clr_len", n, 600);
        rd_check("mid_blank", 13, 0, 8'h20);

        // Form feed clears everything and homes the cursor
        send(8'h43);
        send(8'h0C);
        check("ff_busy", busy, 1);
        check("ff_ccol", cursor_col, 0);
        wait_idle(n);
        check("ff_clr_len", n, 600);
        rd_check("ff_blank", 0, 0, 8'h20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
